// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: drives a 1-cycle synchronous ROM, tags words with their PC,
// buffers them in a DEPTH-entry FIFO for decode, and supports redirect/flush and halt.
module fetch_queue_unit #(
   parameter int                   PC_WIDTH    = 8,
   parameter int                   INSTR_WIDTH = 32,
   parameter int                   DEPTH       = 4,
   parameter int                   PC_STEP     = 1,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
   input  logic                       MAX10_CLK1_50,
   input  logic                       reset,
   output logic [PC_WIDTH-1:0]        rom_address,
   input  logic [INSTR_WIDTH-1:0]     rom_q,
   input  logic                       redirect_valid,
   input  logic [PC_WIDTH-1:0]        redirect_target,
   input  logic                       halt,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [INSTR_WIDTH-1:0]     instr_data,
   output logic [PC_WIDTH-1:0]        instr_pc,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       fetch_state
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0]          DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [PC_WIDTH-1:0]  STEP_C  = PC_WIDTH'(PC_STEP);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t                 state;
   logic [PC_WIDTH-1:0]    fetch_pc;
   logic [PC_WIDTH-1:0]    req_pc;
   logic                   pending;
   logic [CW-1:0]          count;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [INSTR_WIDTH-1:0] mem_data [DEPTH];
   logic [PC_WIDTH-1:0]    mem_pc   [DEPTH];

   logic       pop;
   logic       push;
   logic       issue;
   logic [CW:0] credit;

   assign instr_valid = (count != '0);
   assign pop         = instr_valid & instr_ready;
   // A redirect drops the response arriving this cycle; it belongs to the old stream.
   assign push        = pending & ~redirect_valid;
   // In-flight request reserves a slot so the FIFO can never overflow.
   assign credit      = {1'b0, count} + (CW+1)'(pending) - (CW+1)'(pop);
   assign issue       = redirect_valid | ((state == RUN) & ~halt & (credit < DEPTH_C));

   assign rom_address = redirect_valid ? redirect_target : fetch_pc;
   assign instr_data  = instr_valid ? mem_data[rd_ptr] : '0;
   assign instr_pc    = instr_valid ? mem_pc[rd_ptr]   : '0;
   assign fifo_count  = count;
   assign fetch_state = (state == HALT);

   always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         pending  <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state   <= halt ? HALT : RUN;
         pending <= issue;
         if (issue) begin
            fetch_pc <= rom_address + STEP_C;
            req_pc   <= rom_address;
         end
         if (redirect_valid) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (push) begin
         mem_data[wr_ptr] <= rom_q;
         mem_pc[wr_ptr]   <= req_pc;
      end
   end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized ready/halt/redirect/reset traffic.
module tb_fetch_queue_unit;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rom_address, rom_address2;
   logic [31:0] rom_q = '0, rom_q2 = '0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_target = '0;
   logic        halt = 1'b0;
   logic        instr_valid, instr_valid2;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data, instr_data2;
   logic [7:0]  instr_pc, instr_pc2;
   logic [2:0]  fifo_count, fifo_count2;
   logic        fetch_state, fetch_state2;

   logic [31:0] rom_mem [256];
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   fetch_queue_unit u_dut (
      .MAX10_CLK1_50(clk), .reset(rst_n), .rom_address(rom_address), .rom_q(rom_q),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target), .halt(halt),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
      .instr_pc(instr_pc), .fifo_count(fifo_count), .fetch_state(fetch_state));

   fetch_queue_unit #(.RESET_PC(8'hFE)) u_wrap (
      .MAX10_CLK1_50(clk), .reset(rst_n), .rom_address(rom_address2), .rom_q(rom_q2),
      .redirect_valid(1'b0), .redirect_target(8'h00), .halt(1'b0),
      .instr_valid(instr_valid2), .instr_ready(1'b1), .instr_data(instr_data2),
      .instr_pc(instr_pc2), .fifo_count(fifo_count2), .fetch_state(fetch_state2));

   always @(posedge clk) begin
      rom_q  <= rom_mem[rom_address];
      rom_q2 <= rom_mem[rom_address2];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the queue holds exactly what decode may see, in order.
   typedef struct { logic [7:0] pc; logic [31:0] data; } ent_t;
   ent_t       q[$];
   logic [7:0] m_fetch_pc, m_req_pc;
   bit         m_pend, m_halt;

   task automatic m_reset();
      q.delete();
      m_fetch_pc = 8'h00;
      m_req_pc   = 8'h00;
      m_pend     = 1'b0;
      m_halt     = 1'b0;
   endtask

   task automatic m_step();
      bit         pop;
      bit         iss;
      logic [7:0] addr;
      pop  = (q.size() > 0) && instr_ready;
      addr = redirect_valid ? redirect_target : m_fetch_pc;
      iss  = redirect_valid || (!m_halt && !halt && (q.size() + int'(m_pend) - int'(pop)) < D);
      if (pop) void'(q.pop_front());
      if (redirect_valid) q.delete();
      else if (m_pend) q.push_back(ent_t'{m_req_pc, rom_mem[m_req_pc]});
      m_pend = iss;
      if (iss) begin
         m_req_pc   = addr;
         m_fetch_pc = addr + 8'd1;
      end
      m_halt = halt;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("m_valid", instr_valid, q.size() > 0);
         check("m_pc", instr_pc, (q.size() > 0) ? q[0].pc : 8'h00);
         check("m_data", instr_data, (q.size() > 0) ? q[0].data : 32'h0);
         check("m_count", fifo_count, q.size());
         check("m_state", fetch_state, m_halt);
         check("m_rom_addr", rom_address, redirect_valid ? redirect_target : m_fetch_pc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      halt = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] wexp [4];
      int got;
      int n;
      for (int i = 0; i < 256; i++) rom_mem[i] = 32'h1000_0000 + i;
      wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00; wexp[3] = 8'h01;

      // Reset release, streaming fetch, plus wrap-around instance
      instr_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 2) begin
            check("a_valid_latency", instr_valid, 0);
            check("w_valid_latency", instr_valid2, 0);
         end else begin
            check("a_pc_seq", instr_pc, k - 2);
            check("a_data_seq", instr_data, 32'h1000_0000 + k - 2);
            check("w_state", fetch_state2, 0);
            check("w_count", fifo_count2, 1);
            if (k < 6) check("w_pc_wrap", instr_pc2, wexp[k-2]);
            check("w_data", instr_data2, rom_mem[wexp[k-2]]);
         end
      end

      // Back-pressure: queue saturates, nothing lost
      instr_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      check("b_count_full", fifo_count, 4);
      check("b_pc_hold", rom_address, 8'h04);
      instr_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 8; c++) begin
         @(negedge clk);
         if (instr_valid) begin
            check("b_order", instr_pc, got);
            got++;
         end
      end
      check("b_delivered", got, 8);

      // Redirect with pop in the same cycle
      instr_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 20 && fifo_count != 3; c++) tick();
      check("c_count3", fifo_count, 3);
      redirect_valid = 1'b1;
      redirect_target = 8'h40;
      instr_ready = 1'b1;
      @(negedge clk);
      check("c_popped_pc", instr_pc, 8'h00);
      tick();
      redirect_valid = 1'b0;
      check("c_flushed", fifo_count, 0);
      @(negedge clk);
      check("c_gap_valid", instr_valid, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("c_target_valid", instr_valid, 1);
         check("c_target_pc", instr_pc, 8'h40 + k);
      end

      // Halt, then redirect while halted
      instr_ready = 1'b1;
      do_reset();
      repeat (6) tick();
      halt = 1'b1;
      tick();
      n = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) n++;
      end
      check("e_after_halt_le1", n <= 1, 1);
      check("e_state_halt", fetch_state, 1);
      tick();
      redirect_valid = 1'b1;
      redirect_target = 8'h10;
      tick();
      redirect_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            n++;
            check("e_redirect_pc", instr_pc, 8'h10);
         end
      end
      check("e_redirect_words", n, 1);
      check("e_still_halt", fetch_state, 1);
      tick();
      halt = 1'b0;

      // Reset mid-stream with count=2 and a request in flight
      instr_ready = 1'b0;
      do_reset();
      repeat (3) tick();
      check("f_count2", fifo_count, 2);
      rst_n = 1'b0;
      #1;
      check("f_rst_valid", instr_valid, 0);
      check("f_rst_count", fifo_count, 0);
      check("f_rst_pc", instr_pc, 0);
      check("f_rst_data", instr_data, 0);
      check("f_rst_addr", rom_address, 0);
      tick();
      rst_n = 1'b1;
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 2) begin
            check("f_first_valid", instr_valid, 1);
            check("f_first_pc", instr_pc, 8'h00);
         end
      end

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!rst_n) rst_n = 1'b1;
         instr_ready     = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) halt = ~halt;
         redirect_valid  = ($urandom_range(0, 15) == 0);
         redirect_target = 8'($urandom);
         if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation core. Replaces the bare PC counter plus the branch/jump/jr address muxes.
- Drives the synchronous instruction ROM (1-cycle read latency) and tags each returned word with its PC.
- Buffers fetched words in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/jr target) with flush, and a halt mode.

Parameters:
- PC_WIDTH, 8, width of PC and ROM address
- INSTR_WIDTH, 32, instruction word width
- DEPTH, 4, FIFO entries; power of two, at least 2
- PC_STEP, 1, PC increment per sequential fetch
- RESET_PC, 0, first fetch address after reset

Ports:
- MAX10_CLK1_50  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- rom_address  out  PC_WIDTH  ROM read address, sampled by ROM every edge
- rom_q  in  INSTR_WIDTH  ROM data, valid one cycle after address
- redirect_valid  in  1  load new fetch target, flush queue
- redirect_target  in  PC_WIDTH  new fetch PC
- halt  in  1  stop issuing new fetches while high
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr_data  out  INSTR_WIDTH  head instruction
- instr_pc  out  PC_WIDTH  PC of head instruction
- fifo_count  out  log2(DEPTH)+1  occupied entries
- fetch_state  out  1  0=RUN, 1=HALT

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; pending=0; FIFO count=0; pointers=0; state=RUN.
  - instr_valid=0, instr_data=0, instr_pc=0, fifo_count=0.
- Outputs when empty: instr_data and instr_pc are forced to 0 whenever instr_valid=0.
- pop = instr_valid & instr_ready.
- issue (rising edge condition) = state==RUN & !halt & (count + pending - pop) < DEPTH.
  - The credit check counts the in-flight request, so the FIFO never overflows.
  - Sustained 1 instr/cycle with DEPTH>=2 when decode is always ready.
- rom_address:
  - redirect_target when redirect_valid=1, else fetch_pc. Combinational.
  - A redirect cycle always issues, regardless of halt or credits, because the queue is flushed that cycle.
- On issue:
  - fetch_pc <= rom_address + PC_STEP, modulo 2^PC_WIDTH; wraps from all-ones to 0 with no error.
  - pending <= 1; req_pc <= rom_address.
- Response: if pending=1 at an edge, write {rom_q, req_pc} at wr_ptr, then pending clears unless a new issue occurs that cycle.
- Latency: issue at cycle t → word on rom_q at t+1 → written at end of t+1 → instr_valid at t+2.
- FIFO pointers: wrap modulo DEPTH. Simultaneous push and pop leave count unchanged. Pop when empty is impossible because instr_valid=0.
- Redirect (redirect_valid=1 at cycle t):
  - A pop in cycle t is honoured: decode owns that instruction.
  - All other FIFO entries are discarded. count<=0, pointers<=0.
  - The in-flight response arriving in t is dropped.
  - A new request to redirect_target is issued in t; its pending bit survives the flush.
  - First target instruction appears with instr_valid at t+2.
  - fetch_pc <= redirect_target + PC_STEP.
- Halt FSM:
  - RUN→HALT when halt=1 at an edge. HALT→RUN when halt=0.
  - In HALT: no new issue except on redirect. The in-flight response still completes and queued entries still drain.
  - Redirect in HALT updates fetch_pc and flushes, but state stays HALT.
- Reset mid-operation: everything returns to reset values immediately. The response to a pre-reset request is never written.
- Full queue (count==DEPTH): no issue. fetch_pc holds. rom_address holds fetch_pc.

Test Plan:
- Reset release, instr_ready=1, ROM[i]=0x1000_0000+i → instr_valid rises 2 cycles after reset release; instr_pc 0,1,2,3… one per cycle; instr_data matches.
- instr_ready=0 for 10 cycles → fifo_count saturates at 4, fetch_pc holds at 4, no entry lost. Release ready → PCs 0..7 delivered in order.
- Redirect to 0x40 while count=3 and pop active in the same cycle → popped entry consumed, count=0 next edge, next instr_pc=0x40 two cycles later, no stale PCs appear.
- RESET_PC=0xFE, PC_STEP=1 → instr_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- halt=1 for 5 cycles with ready=1 → at most one further word delivered after the halt edge. fetch_state=1. Redirect during halt to 0x10 → exactly one word (PC 0x10) delivered.
- Assert reset low mid-stream with count=2 and pending=1 → all outputs 0 immediately. After release, first instr_pc=RESET_PC.
